// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the core/DMA memory-port arbiter: owner encoding,
// starve-counter width and the default starvation limit.
package dm_arbiter_pkg;

  // Consecutive contended core grants tolerated before the DMA is forced through.
  localparam int unsigned StarveLimitDefault = 4;

  // Wide enough for the largest legal limit (7).
  localparam int unsigned StarveW = 3;

  // Who owns the access issued in the previous cycle; steers the read-data return.
  typedef enum logic [1:0] {
    OwnNone  = 2'd0,
    OwnCore  = 2'd1,
    OwnDmaRd = 2'd2,
    OwnDmaWr = 2'd3
  } owner_e;

  // Owner code for a granted DMA access of the given direction.
  function automatic owner_e dma_owner(input logic we);
    return we ? OwnDmaWr : OwnDmaRd;
  endfunction

endpackage

// File: rtl/dm_arbiter.sv
// Arbitrates a single synchronous-read memory port between the core and a DMA
// requester. The core wins contention unless the DMA has been refused
// STARVE_LIMIT times in a row. Grants are combinational; nothing is buffered.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = StarveLimitDefault
) (
  input  logic        clk,
  input  logic        resetb,
  // Core side
  input  logic [3:0]  c_be,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_di,
  input  logic        c_is_signed,
  output logic [31:0] c_do,
  output logic        c_stall,
  // DMA side
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_di,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_do,
  // Memory side
  output logic [3:0]  m_be,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_di,
  output logic        m_is_signed,
  input  logic [31:0] m_do
);

  localparam logic [StarveW-1:0] Limit = StarveW'(STARVE_LIMIT);

  logic [StarveW-1:0] starve_q, starve_d;
  owner_e             owner_q, owner_d;

  logic c_req;
  logic dma_win;
  logic core_win;

  // Grant decision; everything is forced idle while reset is asserted.
  always_comb begin
    c_req    = resetb & (|c_be);
    dma_win  = resetb & d_req & (~c_req | (starve_q >= Limit));
    core_win = c_req & ~dma_win;
  end

  // Memory-port mux and handshake outputs; the port is all-zero when idle so a
  // stalled core never leaks onto it.
  always_comb begin
    m_be        = 4'h0;
    m_we        = 1'b0;
    m_addr      = 32'h0;
    m_di        = 32'h0;
    m_is_signed = 1'b0;
    d_gnt       = dma_win;
    c_stall     = c_req & dma_win;
    if (dma_win) begin
      m_be   = d_be;
      m_we   = d_we;
      m_addr = d_addr;
      m_di   = d_di;
    end else if (core_win) begin
      m_be        = c_be;
      m_we        = c_we;
      m_addr      = c_addr;
      m_di        = c_di;
      m_is_signed = c_is_signed;
    end
  end

  // Next owner and starve count; the counter only advances while the DMA is
  // actually being refused, so it clears on a DMA grant or a dropped d_req.
  always_comb begin
    starve_d = '0;
    owner_d  = OwnNone;
    if (dma_win) begin
      owner_d = dma_owner(d_we);
    end else if (core_win) begin
      owner_d = OwnCore;
      if (d_req) begin
        starve_d = starve_q + StarveW'(1);
      end
    end
  end

  // Owner and starve-counter state.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      starve_q <= '0;
      owner_q  <= OwnNone;
    end else begin
      starve_q <= starve_d;
      owner_q  <= owner_d;
    end
  end

  // Read data is shared; d_rvalid marks the cycle that belongs to a DMA read.
  always_comb begin
    c_do     = m_do;
    d_do     = m_do;
    d_rvalid = (owner_q == OwnDmaRd);
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a 1-cycle-latency memory model.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        resetb;
  logic [3:0]  c_be;
  logic        c_we;
  logic [31:0] c_addr;
  logic [31:0] c_di;
  logic        c_is_signed;
  logic [31:0] c_do;
  logic        c_stall;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_di;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_do;
  logic [3:0]  m_be;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_di;
  logic        m_is_signed;
  logic [31:0] m_do = 32'h0;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  localparam logic [31:0] MemKey = 32'hA5A5_0000;

  dm_arbiter #(.STARVE_LIMIT(4)) u_dut (
    .clk         (clk),
    .resetb      (resetb),
    .c_be        (c_be),
    .c_we        (c_we),
    .c_addr      (c_addr),
    .c_di        (c_di),
    .c_is_signed (c_is_signed),
    .c_do        (c_do),
    .c_stall     (c_stall),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_be        (d_be),
    .d_addr      (d_addr),
    .d_di        (d_di),
    .d_gnt       (d_gnt),
    .d_rvalid    (d_rvalid),
    .d_do        (d_do),
    .m_be        (m_be),
    .m_we        (m_we),
    .m_addr      (m_addr),
    .m_di        (m_di),
    .m_is_signed (m_is_signed),
    .m_do        (m_do)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: data is a fixed function of the accessed address.
  always @(posedge clk) begin
    if (m_be != 4'h0) m_do <= m_addr ^ MemKey;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] cbe, input logic cwe, input logic [31:0] caddr,
                       input logic [31:0] cdi, input logic csg, input logic dreq,
                       input logic dwe, input logic [3:0] dbe, input logic [31:0] daddr,
                       input logic [31:0] ddi);
    c_be = cbe; c_we = cwe; c_addr = caddr; c_di = cdi; c_is_signed = csg;
    d_req = dreq; d_we = dwe; d_be = dbe; d_addr = daddr; d_di = ddi;
    #1;
  endtask

  task automatic idle();
    drive(4'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    // Reset with all requests active: outputs must still be idle.
    resetb = 1'b0;
    drive(4'hF, 1'b1, 32'h10, 32'h1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h20, 32'h2);
    tick();
    check_eq("rst_m_be", 32'(m_be), 32'h0);
    check_eq("rst_m_we", 32'(m_we), 32'h0);
    check_eq("rst_d_gnt", 32'(d_gnt), 32'h0);
    check_eq("rst_c_stall", 32'(c_stall), 32'h0);
    check_eq("rst_d_rvalid", 32'(d_rvalid), 32'h0);
    resetb = 1'b1;
    idle();
    check_eq("idle_m_be", 32'(m_be), 32'h0);
    check_eq("idle_d_gnt", 32'(d_gnt), 32'h0);
    check_eq("idle_c_stall", 32'(c_stall), 32'h0);
    tick();

    // DMA read alone.
    drive(4'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    check_eq("drd_gnt", 32'(d_gnt), 32'h1);
    check_eq("drd_m_addr", m_addr, 32'h100);
    check_eq("drd_m_we", 32'(m_we), 32'h0);
    check_eq("drd_c_stall", 32'(c_stall), 32'h0);
    tick();
    idle();
    check_eq("drd_rvalid", 32'(d_rvalid), 32'h1);
    check_eq("drd_d_do", d_do, 32'h100 ^ MemKey);
    tick();
    check_eq("drd_rvalid_drop", 32'(d_rvalid), 32'h0);

    // DMA write alone.
    drive(4'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h104, 32'hDEADBEEF);
    check_eq("dwr_gnt", 32'(d_gnt), 32'h1);
    check_eq("dwr_m_we", 32'(m_we), 32'h1);
    check_eq("dwr_m_be", 32'(m_be), 32'h3);
    check_eq("dwr_m_di", m_di, 32'hDEADBEEF);
    tick();
    idle();
    check_eq("dwr_rvalid", 32'(d_rvalid), 32'h0);
    tick();

    // Core write alone.
    drive(4'hC, 1'b1, 32'h20, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check_eq("cwr_m_addr", m_addr, 32'h20);
    check_eq("cwr_m_di", m_di, 32'h1234_5678);
    check_eq("cwr_m_be", 32'(m_be), 32'hC);
    check_eq("cwr_m_we", 32'(m_we), 32'h1);
    check_eq("cwr_m_sign", 32'(m_is_signed), 32'h1);
    check_eq("cwr_d_gnt", 32'(d_gnt), 32'h0);
    check_eq("cwr_c_stall", 32'(c_stall), 32'h0);
    tick();

    // Six contended cycles: core, core, core, core, DMA, core.
    for (int i = 1; i <= 6; i++) begin
      drive(4'hF, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
      if (i == 6) check_eq("st_rvalid_after_dma", 32'(d_rvalid), 32'h1);
      check_eq($sformatf("st%0d_d_gnt", i), 32'(d_gnt), (i == 5) ? 32'h1 : 32'h0);
      check_eq($sformatf("st%0d_c_stall", i), 32'(c_stall), (i == 5) ? 32'h1 : 32'h0);
      check_eq($sformatf("st%0d_m_addr", i), m_addr, (i == 5) ? 32'h200 : 32'h40);
      check_eq($sformatf("st%0d_m_sign", i), 32'(m_is_signed), (i == 5) ? 32'h0 : 32'h1);
      tick();
    end

    // Counter restart: clear, two contended, drop d_req, then five contended.
    idle();
    tick();
    for (int i = 1; i <= 2; i++) begin
      drive(4'hF, 1'b0, 32'h44, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h204, 32'h0);
      check_eq($sformatf("rs_pre%0d_d_gnt", i), 32'(d_gnt), 32'h0);
      tick();
    end
    drive(4'hF, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0, 1'b0, 4'hF, 32'h204, 32'h0);
    check_eq("rs_drop_d_gnt", 32'(d_gnt), 32'h0);
    tick();
    for (int i = 1; i <= 5; i++) begin
      drive(4'hF, 1'b0, 32'h44, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h204, 32'h0);
      check_eq($sformatf("rs%0d_d_gnt", i), 32'(d_gnt), (i == 5) ? 32'h1 : 32'h0);
      if (i == 5) check_eq("rs5_c_stall", 32'(c_stall), 32'h1);
      tick();
    end

    // Reset during a DMA read grant.
    drive(4'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
    check_eq("rg_d_gnt_pre", 32'(d_gnt), 32'h1);
    resetb = 1'b0;
    #1;
    check_eq("rg_m_be", 32'(m_be), 32'h0);
    check_eq("rg_d_gnt", 32'(d_gnt), 32'h0);
    tick();
    resetb = 1'b1;
    idle();
    tick();
    check_eq("rg_rvalid_after", 32'(d_rvalid), 32'h0);

    // Reset in the data cycle of a DMA read aborts the return.
    drive(4'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h304, 32'h0);
    tick();
    idle();
    check_eq("ra_rvalid_pre", 32'(d_rvalid), 32'h1);
    resetb = 1'b0;
    #1;
    check_eq("ra_rvalid_rst", 32'(d_rvalid), 32'h0);
    tick();
    resetb = 1'b1;
    tick();
    check_eq("ra_rvalid_after", 32'(d_rvalid), 32'h0);

    // Alternate core read / DMA read back to back.
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0)
        drive(4'hF, 1'b0, 32'h500 + 32'(i), 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      else
        drive(4'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h600 + 32'(i), 32'h0);
      check_eq($sformatf("alt%0d_d_gnt", i), 32'(d_gnt), (i % 2 == 1) ? 32'h1 : 32'h0);
      tick();
      if (i % 2 == 0) begin
        check_eq($sformatf("alt%0d_rvalid", i), 32'(d_rvalid), 32'h0);
        check_eq($sformatf("alt%0d_c_do", i), c_do, (32'h500 + 32'(i)) ^ MemKey);
      end else begin
        check_eq($sformatf("alt%0d_rvalid", i), 32'(d_rvalid), 32'h1);
        check_eq($sformatf("alt%0d_d_do", i), d_do, (32'h600 + 32'(i)) ^ MemKey);
      end
    end
    idle();
    tick();
    check_eq("alt_end_rvalid", 32'(d_rvalid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, giving the number of consecutive contended core grants before the DMA port is forced a grant (range 1..7).
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 resetb  in  1  asynchronous, active-low reset.
REQ-004 c_be  in  4  core byte enables; c_be != 0 means a core request this cycle.
REQ-005 c_we  in  1  core write enable.
REQ-006 c_addr / c_di  in  32 / 32  core address and write data.
REQ-007 c_is_signed  in  1  core load sign flag, passed through to m_is_signed.
REQ-008 c_do  out  32  core read data, equal to m_do.
REQ-009 c_stall  out  1  core must hold its request unchanged this cycle.
REQ-010 d_req / d_we  in  1 / 1  DMA request and write enable.
REQ-011 d_be / d_addr / d_di  in  4 / 32 / 32  DMA byte enables, address and write data.
REQ-012 d_gnt  out  1  DMA request accepted this cycle.
REQ-013 d_rvalid / d_do  out  1 / 32  DMA read data valid (registered) and read data (= m_do).
REQ-014 m_be / m_we / m_addr / m_di / m_is_signed  out  4 / 1 / 32 / 32 / 1  memory port, synchronous read with 1-cycle latency.
REQ-015 m_do  in  32  memory read data, valid the cycle after the access.

Function
REQ-016 Grant SHALL be combinational from the current requests and the registered starve counter; no request is buffered.
REQ-017 No request: m_be=0, m_we=0, d_gnt=0, c_stall=0.
REQ-018 Core only: core fields drive the memory port, c_stall=0, d_gnt=0.
REQ-019 DMA only: DMA fields drive the memory port, d_gnt=1, c_stall=0.
REQ-020 Both, starve_cnt < STARVE_LIMIT: core wins, c_stall=0, d_gnt=0, starve_cnt increments.
REQ-021 Both, starve_cnt == STARVE_LIMIT: DMA wins, d_gnt=1, c_stall=1, starve_cnt clears to 0.
REQ-022 starve_cnt SHALL clear on any DMA grant and whenever d_req=0; it SHALL never exceed STARVE_LIMIT.
REQ-023 The owner register SHALL take values NONE, CORE, DMA_RD, DMA_WR, loaded every cycle from the grant and access type.
REQ-024 d_rvalid SHALL be 1 exactly in the cycle after a DMA read grant (owner == DMA_RD), else 0.
REQ-025 A DMA request not granted SHALL be held by the requester; d_gnt never asserts without d_req.
REQ-026 Back-to-back grants to different owners SHALL incur no idle cycle; read data of cycle N is routed by owner latched at cycle N.
REQ-027 When c_stall=1 the memory port SHALL carry no core field.

Reset
REQ-028 While resetb=0: starve_cnt=0, owner=NONE, d_rvalid=0, and m_be=0, m_we=0, d_gnt=0, c_stall=0 regardless of inputs.
REQ-029 Reset asserted mid-access SHALL abort it; no d_rvalid follows reset release.

Structure
REQ-030 Owner encoding and STARVE_LIMIT default SHALL live in a shared include alongside the existing core headers.
REQ-031 Grant logic and owner/starve registers SHALL be in one module; no sub-module is required.

Verification
REQ-032 DMA read d_addr=0x100 alone -> d_gnt=1, m_addr=0x100; next cycle d_rvalid=1, d_do=m_do.
REQ-033 Core c_be=4'hF and d_req=1 held 6 cycles, STARVE_LIMIT=4 -> core granted cycles 1-4, DMA granted cycle 5 with c_stall=1, core cycle 6.
REQ-034 d_req drops after 2 contended cycles, reasserts -> counter restarts at 0; DMA waits another 4 contended cycles.
REQ-035 DMA write d_be=4'b0011, d_di=0xDEADBEEF -> m_we=1, m_be=4'b0011, m_di=0xDEADBEEF, d_rvalid stays 0.
REQ-036 resetb low during DMA read grant -> d_rvalid=0 after release, m_be=0 during reset.
REQ-037 Alternate core read / DMA read each cycle -> d_rvalid only after DMA cycles, c_do matches core-cycle data.
